// File: rtl/ysyx_23060191_csr_file.sv
// ysyx_23060191_csr_file
// Machine-mode CSR file: mstatus, mtvec, mepc, mcause and an optional 64-bit
// cycle counter. Handles the ecall/mret side effects and supplies trap/return PCs.
// Optional feature macro: CSR_MCYCLE_EN (adds mcycle 0xB00 / mcycleh 0xB80).
module ysyx_23060191_csr_file #(
  parameter int CPU_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [11:0]          i_csr_raddr,
  output logic [CPU_WIDTH-1:0] o_csr_rdata,
  output logic                 o_csr_hit,
  input  logic                 i_csr_wr_en,
  input  logic [11:0]          i_csr_waddr,
  input  logic [CPU_WIDTH-1:0] i_csr_wdata,
  input  logic                 i_ecall,
  input  logic                 i_mret,
  input  logic [CPU_WIDTH-1:0] i_pc,
  output logic [CPU_WIDTH-1:0] o_trap_pc,
  output logic [CPU_WIDTH-1:0] o_mret_pc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
`ifdef CSR_MCYCLE_EN
  localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;
`endif

  localparam logic [CPU_WIDTH-1:0] ALIGN_MASK  = ~CPU_WIDTH'(3);
  localparam logic [CPU_WIDTH-1:0] CAUSE_ECALL = CPU_WIDTH'(11);

  // Only MIE/MPIE are stored; MPP reads as constant 11.
  logic                 mie_q;
  logic                 mpie_q;
  logic [CPU_WIDTH-1:0] mtvec_q;
  logic [CPU_WIDTH-1:0] mepc_q;
  logic [CPU_WIDTH-1:0] mcause_q;
  logic [CPU_WIDTH-1:0] mstatus_rd;

  logic wr_mstatus;
  logic wr_mtvec;
  logic wr_mepc;
  logic wr_mcause;

  assign wr_mstatus = i_csr_wr_en && (i_csr_waddr == ADDR_MSTATUS);
  assign wr_mtvec   = i_csr_wr_en && (i_csr_waddr == ADDR_MTVEC);
  assign wr_mepc    = i_csr_wr_en && (i_csr_waddr == ADDR_MEPC);
  assign wr_mcause  = i_csr_wr_en && (i_csr_waddr == ADDR_MCAUSE);

  // mstatus interrupt-enable stack: ecall > mret > software write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mie_q  <= 1'b0;
      mpie_q <= 1'b0;
    end else if (i_ecall) begin
      mpie_q <= mie_q;
      mie_q  <= 1'b0;
    end else if (i_mret) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (wr_mstatus) begin
      mie_q  <= i_csr_wdata[3];
      mpie_q <= i_csr_wdata[7];
    end
  end

  // mtvec: direct mode only, never touched by traps
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtvec_q <= '0;
    end else if (wr_mtvec) begin
      mtvec_q <= i_csr_wdata & ALIGN_MASK;
    end
  end

  // mepc/mcause: ecall capture has priority over a software write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mepc_q   <= '0;
      mcause_q <= '0;
    end else if (i_ecall) begin
      mepc_q   <= i_pc & ALIGN_MASK;
      mcause_q <= CAUSE_ECALL;
    end else begin
      if (wr_mepc) begin
        mepc_q <= i_csr_wdata & ALIGN_MASK;
      end
      if (wr_mcause) begin
        mcause_q <= i_csr_wdata;
      end
    end
  end

`ifdef CSR_MCYCLE_EN
  logic [CPU_WIDTH-1:0] cyc_lo_q;
  logic [CPU_WIDTH-1:0] cyc_hi_q;
  logic                 wr_mcycle;
  logic                 wr_mcycleh;

  assign wr_mcycle  = i_csr_wr_en && (i_csr_waddr == ADDR_MCYCLE);
  assign wr_mcycleh = i_csr_wr_en && (i_csr_waddr == ADDR_MCYCLEH);

  // 64-bit cycle counter; a write to either half suppresses that cycle's increment
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cyc_lo_q <= '0;
      cyc_hi_q <= '0;
    end else if (wr_mcycle) begin
      cyc_lo_q <= i_csr_wdata;
    end else if (wr_mcycleh) begin
      cyc_hi_q <= i_csr_wdata;
    end else begin
      {cyc_hi_q, cyc_lo_q} <= {cyc_hi_q, cyc_lo_q} + 1'b1;
    end
  end
`endif

  // mstatus read view: MPP hardwired, MIE/MPIE from storage, rest zero
  always_comb begin
    mstatus_rd     = '0;
    mstatus_rd[12] = 1'b1;
    mstatus_rd[11] = 1'b1;
    mstatus_rd[7]  = mpie_q;
    mstatus_rd[3]  = mie_q;
  end

  // Combinational read mux; unmapped addresses read 0 with no hit
  always_comb begin
    o_csr_rdata = '0;
    o_csr_hit   = 1'b0;
    case (i_csr_raddr)
      ADDR_MSTATUS: begin o_csr_rdata = mstatus_rd; o_csr_hit = 1'b1; end
      ADDR_MTVEC:   begin o_csr_rdata = mtvec_q;    o_csr_hit = 1'b1; end
      ADDR_MEPC:    begin o_csr_rdata = mepc_q;     o_csr_hit = 1'b1; end
      ADDR_MCAUSE:  begin o_csr_rdata = mcause_q;   o_csr_hit = 1'b1; end
`ifdef CSR_MCYCLE_EN
      ADDR_MCYCLE:  begin o_csr_rdata = cyc_lo_q;   o_csr_hit = 1'b1; end
      ADDR_MCYCLEH: begin o_csr_rdata = cyc_hi_q;   o_csr_hit = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign o_trap_pc = mtvec_q;
  assign o_mret_pc = mepc_q;

endmodule

// File: tb/tb_ysyx_23060191_csr_file.sv
// Self-checking bench for ysyx_23060191_csr_file: directed literal checks plus
// randomized traffic compared every cycle against a behavioural CSR model.
module tb_ysyx_23060191_csr_file;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [11:0] i_csr_raddr;
  logic [31:0] o_csr_rdata;
  logic        o_csr_hit;
  logic        i_csr_wr_en;
  logic [11:0] i_csr_waddr;
  logic [31:0] i_csr_wdata;
  logic        i_ecall;
  logic        i_mret;
  logic [31:0] i_pc;
  logic [31:0] o_trap_pc;
  logic [31:0] o_mret_pc;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_23060191_csr_file #(.CPU_WIDTH(32)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_csr_raddr (i_csr_raddr),
    .o_csr_rdata (o_csr_rdata),
    .o_csr_hit   (o_csr_hit),
    .i_csr_wr_en (i_csr_wr_en),
    .i_csr_waddr (i_csr_waddr),
    .i_csr_wdata (i_csr_wdata),
    .i_ecall     (i_ecall),
    .i_mret      (i_mret),
    .i_pc        (i_pc),
    .o_trap_pc   (o_trap_pc),
    .o_mret_pc   (o_mret_pc)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- behavioural model ----------------
  bit          m_valid = 1'b0;
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mepc, m_mcause;
  logic [63:0] m_cyc;

`ifdef CSR_MCYCLE_EN
  localparam bit HAS_CYC = 1'b1;
`else
  localparam bit HAS_CYC = 1'b0;
`endif

  // Architectural effect of one clock edge; later assignments override earlier ones
  always @(posedge i_clk) begin
    if (i_rst) begin
      m_valid  <= 1'b1;
      m_mie    <= 1'b0;
      m_mpie   <= 1'b0;
      m_mtvec  <= 32'h0;
      m_mepc   <= 32'h0;
      m_mcause <= 32'h0;
      m_cyc    <= 64'h0;
    end else if (m_valid) begin
      m_cyc <= m_cyc + 64'd1;
      if (i_csr_wr_en) begin
        case (i_csr_waddr)
          12'h300: begin m_mie <= i_csr_wdata[3]; m_mpie <= i_csr_wdata[7]; end
          12'h305: m_mtvec  <= {i_csr_wdata[31:2], 2'b00};
          12'h341: m_mepc   <= {i_csr_wdata[31:2], 2'b00};
          12'h342: m_mcause <= i_csr_wdata;
          12'hB00: if (HAS_CYC) m_cyc <= {m_cyc[63:32], i_csr_wdata};
          12'hB80: if (HAS_CYC) m_cyc <= {i_csr_wdata, m_cyc[31:0]};
          default: ;
        endcase
      end
      if (i_ecall) begin
        m_mepc   <= {i_pc[31:2], 2'b00};
        m_mcause <= 32'd11;
        m_mpie   <= m_mie;
        m_mie    <= 1'b0;
      end else if (i_mret) begin
        m_mie  <= m_mpie;
        m_mpie <= 1'b1;
      end
    end
  end

  function automatic logic [32:0] mread(input logic [11:0] a);
    case (a)
      12'h300: return {1'b1, 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0)};
      12'h305: return {1'b1, m_mtvec};
      12'h341: return {1'b1, m_mepc};
      12'h342: return {1'b1, m_mcause};
      12'hB00: return HAS_CYC ? {1'b1, m_cyc[31:0]}  : 33'h0;
      12'hB80: return HAS_CYC ? {1'b1, m_cyc[63:32]} : 33'h0;
      default: return 33'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Single compare process: all outputs against the model, every cycle
  always @(negedge i_clk) begin
    logic [32:0] r;
    if (m_valid) begin
      r = mread(i_csr_raddr);
      chk($sformatf("cmp_rdata@%h", i_csr_raddr), o_csr_rdata, r[31:0]);
      chk($sformatf("cmp_hit@%h", i_csr_raddr), {31'b0, o_csr_hit}, {31'b0, r[32]});
      chk("cmp_trap_pc", o_trap_pc, m_mtvec);
      chk("cmp_mret_pc", o_mret_pc, m_mepc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                     input logic ec, input logic mr, input logic [31:0] pc);
    i_csr_wr_en = we;
    i_csr_waddr = wa;
    i_csr_wdata = wd;
    i_ecall     = ec;
    i_mret      = mr;
    i_pc        = pc;
    @(posedge i_clk);
    #2;
    i_csr_wr_en = 1'b0;
    i_ecall     = 1'b0;
    i_mret      = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic expect_read(input string name, input logic [11:0] a,
                             input logic [31:0] d, input logic h);
    i_csr_raddr = a;
    #1;
    chk({name, "_data"}, o_csr_rdata, d);
    chk({name, "_hit"}, {31'b0, o_csr_hit}, {31'b0, h});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  localparam logic [11:0] ADDRS [8] = '{12'h300, 12'h305, 12'h341, 12'h342,
                                        12'hB00, 12'hB80, 12'h7C0, 12'h344};

  initial begin
    i_rst = 1'b1;
    i_csr_raddr = 12'h300;
    i_csr_wr_en = 1'b0;
    i_csr_waddr = 12'h0;
    i_csr_wdata = 32'h0;
    i_ecall = 1'b0;
    i_mret = 1'b0;
    i_pc = 32'h0;
    repeat (2) @(posedge i_clk);
    #2;
    i_rst = 1'b0;

    // reset values
    expect_read("rst_mstatus", 12'h300, 32'h1800, 1'b1);
    expect_read("rst_mtvec",   12'h305, 32'h0, 1'b1);
    expect_read("rst_mepc",    12'h341, 32'h0, 1'b1);
    expect_read("rst_mcause",  12'h342, 32'h0, 1'b1);
    expect_read("rst_mcycle",  12'hB00, 32'h0, HAS_CYC);

    // write masks
    cyc(1'b1, 12'h300, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    expect_read("mask_mstatus", 12'h300, 32'h1888, 1'b1);
    cyc(1'b1, 12'h305, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    expect_read("mask_mtvec", 12'h305, 32'hFFFF_FFFC, 1'b1);
    cyc(1'b1, 12'h7C0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    expect_read("unmapped", 12'h7C0, 32'h0, 1'b0);

    // ecall then mret
    cyc(1'b1, 12'h300, 32'h0000_0008, 1'b0, 1'b0, 32'h0);
    expect_read("pre_ecall_mstatus", 12'h300, 32'h1808, 1'b1);
    cyc(1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h8000_0104);
    expect_read("ecall_mepc",    12'h341, 32'h8000_0104, 1'b1);
    expect_read("ecall_mcause",  12'h342, 32'd11, 1'b1);
    expect_read("ecall_mstatus", 12'h300, 32'h1880, 1'b1);
    cyc(1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    expect_read("mret_mstatus", 12'h300, 32'h1888, 1'b1);

    // collisions
    cyc(1'b1, 12'h341, 32'h0000_1234, 1'b1, 1'b0, 32'h8000_0200);
    expect_read("ecall_vs_mepc_wr", 12'h341, 32'h8000_0200, 1'b1);
    cyc(1'b1, 12'h305, 32'h8000_0000, 1'b1, 1'b0, 32'h8000_0300);
    expect_read("ecall_with_mtvec_wr", 12'h305, 32'h8000_0000, 1'b1);
    expect_read("ecall_with_mtvec_mepc", 12'h341, 32'h8000_0300, 1'b1);
    chk("trap_pc_lit", o_trap_pc, 32'h8000_0000);
    chk("mret_pc_lit", o_mret_pc, 32'h8000_0300);
    cyc(1'b1, 12'h300, 32'h0000_0080, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 32'h8000_0404);
    expect_read("ecall_mret_mstatus", 12'h300, 32'h1800, 1'b1);
    expect_read("ecall_mret_mepc", 12'h341, 32'h8000_0404, 1'b1);

    // read-during-write on mcause (currently 11)
    i_csr_raddr = 12'h342;
    i_csr_wr_en = 1'b1;
    i_csr_waddr = 12'h342;
    i_csr_wdata = 32'd5;
    #1;
    chk("rdw_old", o_csr_rdata, 32'd11);
    @(posedge i_clk);
    #2;
    i_csr_wr_en = 1'b0;
    expect_read("rdw_new", 12'h342, 32'd5, 1'b1);

    // counter wrap across the low word
    cyc(1'b1, 12'hB80, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 12'hB00, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0);
    expect_read("cyc_wr_lo", 12'hB00, HAS_CYC ? 32'hFFFF_FFFE : 32'h0, HAS_CYC);
    expect_read("cyc_wr_hi", 12'hB80, 32'h0, HAS_CYC);
    idle();
    idle();
    expect_read("cyc_wrap_lo", 12'hB00, 32'h0, HAS_CYC);
    expect_read("cyc_wrap_hi", 12'hB80, HAS_CYC ? 32'h1 : 32'h0, HAS_CYC);

    // reset held with competing ecall/write
    i_rst = 1'b1;
    cyc(1'b1, 12'h305, 32'h1234_5678, 1'b1, 1'b0, 32'h8000_0800);
    i_rst = 1'b0;
    expect_read("rst2_mtvec",   12'h305, 32'h0, 1'b1);
    expect_read("rst2_mstatus", 12'h300, 32'h1800, 1'b1);
    expect_read("rst2_mcycle0", 12'hB00, 32'h0, HAS_CYC);
    idle();
    expect_read("rst2_mcycle1", 12'hB00, HAS_CYC ? 32'h1 : 32'h0, HAS_CYC);

    // randomized traffic, checked by the compare process
    for (int k = 0; k < 2500; k++) begin
      logic [31:0] wd;
      logic [11:0] wa;
      wa = ADDRS[$urandom_range(0, 7)];
      wd = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      i_csr_raddr = ADDRS[$urandom_range(0, 7)];
      i_rst = ($urandom_range(0, 199) == 0);
      cyc($urandom_range(0, 1) == 1, wa, wd,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom);
    end
    i_rst = 1'b0;
    idle();
    @(negedge i_clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
